// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick/square outputs with
// shadowed divisor reload at the period wrap, plus a free-running prescaler tap.
module clk_div_multi #(
  parameter int WIDTH   = 25,
  parameter int NCH     = 4,
  parameter int DEF_DIV = 1499999,
  parameter int TAP     = 16,
  localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             div_load,
  input  logic [SELW-1:0]  div_sel,
  input  logic [WIDTH-1:0] div_val,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic             tap
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);
  // Bits above TAP never reach an output, so only TAP+1 prescaler bits are kept;
  // the tap sequence is identical to that of the full-width counter.
  localparam int PW = TAP + 1;

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (sync) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  assign tap = presc[TAP];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] shd;
    logic [WIDTH-1:0] shd_nxt;
    logic             ld;
    logic             wrap;
    logic             tick_r;
    logic             sq_r;

    // div_load is a single-cycle strobe; selects at or above NCH match no channel.
    assign ld      = div_load && (div_sel == SELW'(g));
    assign shd_nxt = ld ? div_val : shd;
    assign wrap    = (cnt >= act);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        act    <= DEF;
        shd    <= DEF;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        sq_r   <= 1'b0;
        tick_r <= 1'b0;
        act    <= shd_nxt;
        shd    <= shd_nxt;
      end else if (!en[g]) begin
        tick_r <= 1'b0;
        // An idle channel has no period in flight, so a load takes effect at once.
        if (ld) begin
          shd <= div_val;
          act <= div_val;
          cnt <= '0;
        end
      end else begin
        shd <= shd_nxt;
        if (wrap) begin
          cnt    <= '0;
          sq_r   <= ~sq_r;
          tick_r <= 1'b1;
          act    <= shd_nxt;
        end else begin
          cnt    <= cnt + WIDTH'(1);
          tick_r <= 1'b0;
        end
      end
    end

    assign tick[g] = tick_r;
    assign sq[g]   = sq_r;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed period scenarios plus random traffic checked
// every cycle against a countdown-based reference model.
module tb_clk_div_multi;

  localparam int W   = 8;
  localparam int N   = 3;
  localparam int DEF = 5;
  localparam int TP  = 3;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  en = '0;
  logic          sync = 1'b0;
  logic          div_load = 1'b0;
  logic [SW-1:0] div_sel = '0;
  logic [W-1:0]  div_val = '0;
  logic [N-1:0]  tick;
  logic [N-1:0]  sq;
  logic          tap;

  always #5 clk = ~clk;

  clk_div_multi #(.WIDTH(W), .NCH(N), .DEF_DIV(DEF), .TAP(TP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_load(div_load),
    .div_sel(div_sel), .div_val(div_val), .tick(tick), .sq(sq), .tap(tap)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference: each channel counts down the edges left until its next wrap.
  int m_act[N];
  int m_shd[N];
  int m_left[N];
  int m_tick[N];
  int m_sq[N];
  int m_presc;

  int edge_n;
  int first_t[N];
  int second_t[N];
  int tick_n[N];
  int sq_tog[N];
  int sq_hi[N];
  int tap_first;
  logic [N-1:0] prev_sq;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = DEF; m_shd[i] = DEF; m_left[i] = DEF;
      m_tick[i] = 0; m_sq[i] = 0;
    end
    m_presc = 0;
  endtask

  task automatic model_edge();
    m_presc = sync ? 0 : (m_presc + 1) % (1 << W);
    for (int i = 0; i < N; i++) begin
      bit ld;
      ld = div_load && (int'(div_sel) == i);
      if (sync) begin
        if (ld) m_shd[i] = int'(div_val);
        m_act[i] = m_shd[i]; m_left[i] = m_act[i];
        m_sq[i] = 0; m_tick[i] = 0;
      end else if (!en[i]) begin
        m_tick[i] = 0;
        if (ld) begin
          m_shd[i] = int'(div_val); m_act[i] = m_shd[i]; m_left[i] = m_act[i];
        end
      end else begin
        if (ld) m_shd[i] = int'(div_val);
        if (m_left[i] == 0) begin
          m_tick[i] = 1; m_sq[i] ^= 1;
          m_act[i] = m_shd[i]; m_left[i] = m_act[i];
        end else begin
          m_left[i]--; m_tick[i] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < N; i++) begin
      check($sformatf("tick%0d", i), int'(tick[i]), m_tick[i]);
      check($sformatf("sq%0d", i), int'(sq[i]), m_sq[i]);
    end
    check("tap", int'(tap), (m_presc >> TP) & 1);
  endtask

  task automatic clr_stats();
    edge_n = 0; tap_first = 0; prev_sq = sq;
    for (int i = 0; i < N; i++) begin
      first_t[i] = 0; second_t[i] = 0; tick_n[i] = 0; sq_tog[i] = 0; sq_hi[i] = 0;
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result.
  task automatic cyc(input logic [N-1:0] e, input bit s, input bit ld,
                     input int sel, input int val);
    en = e; sync = s; div_load = ld; div_sel = SW'(sel); div_val = W'(val);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    edge_n++;
    for (int i = 0; i < N; i++) begin
      if (tick[i]) begin
        tick_n[i]++;
        if (first_t[i] == 0) first_t[i] = edge_n;
        else if (second_t[i] == 0) second_t[i] = edge_n;
      end
      if (sq[i] != prev_sq[i]) sq_tog[i]++;
      if (sq[i]) sq_hi[i]++;
    end
    if (tap && tap_first == 0) tap_first = edge_n;
    prev_sq = sq;
    sync = 1'b0; div_load = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tick", int'(tick), 0);
    check("rst_sq", int'(sq), 0);
    check("rst_tap", int'(tap), 0);
    rst_n = 1'b1;

    // Divide-by-4 on ch0 loaded while idle; ch1 stays quiet.
    cyc(3'b000, 0, 1, 0, 3);
    clr_stats();
    repeat (16) cyc(3'b001, 0, 0, 0, 0);
    check("n3_first", first_t[0], 4);
    check("n3_second", second_t[0], 8);
    check("n3_ticks", tick_n[0], 4);
    check("n3_sq_toggles", sq_tog[0], 4);
    check("idle_ch1_ticks", tick_n[1], 0);
    check("idle_ch1_sq", sq_hi[1], 0);

    // Mid-period divisor change on ch0: old period completes first.
    cyc(3'b000, 0, 1, 0, 9);
    clr_stats();
    repeat (4) cyc(3'b001, 0, 0, 0, 0);
    cyc(3'b001, 0, 1, 0, 2);
    repeat (11) cyc(3'b001, 0, 0, 0, 0);
    check("mid_first", first_t[0], 10);
    check("mid_second", second_t[0], 13);
    check("mid_ticks", tick_n[0], 3);

    // N=0 on ch1: tick every cycle, sq at clk/2.
    cyc(3'b000, 0, 1, 1, 0);
    clr_stats();
    repeat (8) cyc(3'b010, 0, 0, 0, 0);
    check("n0_ticks", tick_n[1], 8);
    check("n0_sq_toggles", sq_tog[1], 8);

    // Sync restart with a simultaneous out-of-range load that must be ignored.
    cyc(3'b000, 0, 1, 0, 4);
    cyc(3'b000, 0, 1, 1, 6);
    repeat (9) cyc(3'b011, 0, 0, 0, 0);
    clr_stats();
    cyc(3'b011, 1, 1, 3, 1);
    check("sync_tick", int'(tick), 0);
    check("sync_sq", int'(sq), 0);
    repeat (15) cyc(3'b011, 0, 0, 0, 0);
    check("sync_first0", first_t[0], 6);
    check("sync_first1", first_t[1], 8);
    check("sync_second0", second_t[0], 11);
    check("sync_second1", second_t[1], 15);

    // Random traffic, including invalid selects and occasional sync.
    for (int k = 0; k < 400; k++) begin
      cyc(N'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 12));
    end

    // Asynchronous reset between clock edges, then default divisor and tap.
    repeat (3) cyc(3'b111, 0, 1, 2, 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_tick", int'(tick), 0);
    check("async_sq", int'(sq), 0);
    check("async_tap", int'(tap), 0);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    clr_stats();
    repeat (10) cyc(3'b111, 0, 0, 0, 0);
    check("def_first0", first_t[0], DEF + 1);
    check("def_first2", first_t[2], DEF + 1);
    check("tap_first", tap_first, 1 << TP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
